vvmul_arb: RTL and testbench

VVMUL_ARB -- requirements
Module: vvmul_arb

---
 rtl/vvmul_arb_if.sv | 47 ++++
 rtl/vvmul_arb.sv | 117 +++++++++++
 tb/tb_vvmul_arb.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vvmul_arb_if.sv
// ---------------------------------------------------------------------------
// vvmul_arb_if
// Bundles every signal between the vector-multiply arbiter and the
// outside world except clock and reset.
//
//   req_valid  per-requester request valid          (requesters -> arbiter)
//   req_ready  per-requester one-cycle accept strobe (arbiter -> requesters)
//   req_a/x    operand vectors, one pair per requester
//   mul_a/x    operands launched into the shared multiplier
//   mul_y      lane-wise product from the shared multiplier
//   rsp_valid  result held and valid
//   rsp_id     index of the requester owning rsp_y
//   rsp_y      registered result vector
//   rsp_ready  consumer accepts the result
//
// modport master : the arbiter
// modport slave  : requesters, multiplier and response consumer
// ---------------------------------------------------------------------------
interface vvmul_arb_if #(
    parameter int NUM_REQ     = 4,
    parameter int VECTOR_SIZE = 16,
    parameter int INT_SIZE    = 16
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                                req_valid;
    logic [NUM_REQ-1:0]                                req_ready;
    logic [NUM_REQ-1:0][VECTOR_SIZE-1:0][INT_SIZE-1:0] req_a;
    logic [NUM_REQ-1:0][VECTOR_SIZE-1:0][INT_SIZE-1:0] req_x;
    logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]              mul_a;
    logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]              mul_x;
    logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]              mul_y;
    logic                                              rsp_valid;
    logic [ID_W-1:0]                                   rsp_id;
    logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]              rsp_y;
    logic                                              rsp_ready;

    modport master (
        input  req_valid, req_a, req_x, mul_y, rsp_ready,
        output req_ready, mul_a, mul_x, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        output req_valid, req_a, req_x, mul_y, rsp_ready,
        input  req_ready, mul_a, mul_x, rsp_valid, rsp_id, rsp_y
    );
endinterface

// File: rtl/vvmul_arb.sv
// ---------------------------------------------------------------------------
// vvmul_arb
// Round-robin arbiter that shares one pipelined vector multiplier between
// NUM_REQ requesters. One operation is in flight at a time: grant, wait
// MUL_LATENCY cycles for the product, then hold the result until the
// consumer takes it.
//
// Ports
//   clock  single clock, rising edge
//   reset  synchronous, active-high
//   bus    vvmul_arb_if.master (request, multiplier and response signals)
//   busy   high whenever the FSM is not IDLE
//
// State | Meaning
// ------+-----------------------------------------------------------------
// IDLE  | no operation; grant the next valid requester round-robin
// WAIT  | operands launched, counting down the multiplier latency
// HOLD  | result registered, waiting for rsp_ready
// ---------------------------------------------------------------------------
module vvmul_arb #(
    parameter int NUM_REQ     = 4,
    parameter int VECTOR_SIZE = 16,
    parameter int INT_SIZE    = 16,
    parameter int MUL_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    vvmul_arb_if.master bus,
    output logic        busy
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [3:0]         LAT      = 4'(MUL_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t          state;
    logic [3:0]      count;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] pick;
    logic            pick_any;

    // Round-robin search starting just after last_grant. Walking the
    // offsets from the far end down lets the nearest valid requester win.
    always_comb begin : rr_search
        int idx;
        idx      = 0;
        pick     = '0;
        pick_any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                pick     = idx[ID_W-1:0];
                pick_any = 1'b1;
            end
        end
    end

    // The accept strobe is decoded in the same cycle the grant is decided
    // so the requester sees it while its operands are being sampled. It is
    // gated by reset so no grant can happen while reset is asserted.
    assign bus.req_ready = (state == IDLE && !reset && pick_any)
                           ? (ONE_HOT0 << pick) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            count         <= '0;
            last_grant    <= ID_W'(NUM_REQ - 1);
            bus.mul_a     <= '0;
            bus.mul_x     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        bus.mul_a  <= bus.req_a[pick];
                        bus.mul_x  <= bus.req_x[pick];
                        bus.rsp_id <= pick;
                        last_grant <= pick;
                        count      <= LAT;
                        busy       <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    // Product of the launched operands is on mul_y in the
                    // cycle the counter reads 1.
                    if (count == 4'd1) begin
                        bus.rsp_y     <= bus.mul_y;
                        bus.rsp_valid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vvmul_arb.sv
// ---------------------------------------------------------------------------
// tb_vvmul_arb
// Two arbiters (MUL_LATENCY 1 and 4) share the same request stimulus, each
// with its own multiplier model. Directed scenarios check fixed values;
// the random scenario checks against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_vvmul_arb;
    localparam int N  = 4;
    localparam int VS = 16;
    localparam int IS = 16;

    typedef logic [VS-1:0][IS-1:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst       = 1'b1;
    logic [N-1:0]                req_valid = '0;
    logic [N-1:0][VS-1:0][IS-1:0] req_a    = '0;
    logic [N-1:0][VS-1:0][IS-1:0] req_x    = '0;
    logic                        rsp_ready = 1'b0;
    logic                        busy1, busy4;

    int total = 0;
    int bad   = 0;

    vvmul_arb_if #(.NUM_REQ(N), .VECTOR_SIZE(VS), .INT_SIZE(IS)) b1 ();
    vvmul_arb_if #(.NUM_REQ(N), .VECTOR_SIZE(VS), .INT_SIZE(IS)) b4 ();

    vvmul_arb #(.NUM_REQ(N), .VECTOR_SIZE(VS), .INT_SIZE(IS), .MUL_LATENCY(1)) dut1 (
        .clock(clk), .reset(rst), .bus(b1.master), .busy(busy1));
    vvmul_arb #(.NUM_REQ(N), .VECTOR_SIZE(VS), .INT_SIZE(IS), .MUL_LATENCY(4)) dut4 (
        .clock(clk), .reset(rst), .bus(b4.master), .busy(busy4));

    function automatic vec_t vmul(vec_t a, vec_t x);
        vec_t     y;
        bit [31:0] p;
        for (int j = 0; j < VS; j++) begin
            p    = 32'(a[j]) * 32'(x[j]);
            y[j] = p[15:0];
        end
        return y;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int j = 0; j < VS; j++) v[j] = 16'($urandom);
        return v;
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int rr_pick(logic [N-1:0] v, int lg);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (lg + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // shared stimulus, per-DUT multipliers: latency 1 is combinational,
    // latency 4 has three register stages after the multiply
    vec_t pipe4 [3];
    always_ff @(posedge clk) begin
        pipe4[0] <= vmul(b4.mul_a, b4.mul_x);
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
    end

    assign b1.req_valid = req_valid;  assign b4.req_valid = req_valid;
    assign b1.req_a     = req_a;      assign b4.req_a     = req_a;
    assign b1.req_x     = req_x;      assign b4.req_x     = req_x;
    assign b1.rsp_ready = rsp_ready;  assign b4.rsp_ready = rsp_ready;
    assign b1.mul_y     = vmul(b1.mul_a, b1.mul_x);
    assign b4.mul_y     = pipe4[2];

    logic [N-1:0] o_ready [2];
    logic         o_rv    [2];
    logic         o_busy  [2];
    logic [1:0]   o_id    [2];
    vec_t         o_y     [2];
    vec_t         o_ma    [2];
    vec_t         o_mx    [2];

    assign o_ready[0] = b1.req_ready;  assign o_ready[1] = b4.req_ready;
    assign o_rv[0]    = b1.rsp_valid;  assign o_rv[1]    = b4.rsp_valid;
    assign o_busy[0]  = busy1;         assign o_busy[1]  = busy4;
    assign o_id[0]    = b1.rsp_id;     assign o_id[1]    = b4.rsp_id;
    assign o_y[0]     = b1.rsp_y;      assign o_y[1]     = b4.rsp_y;
    assign o_ma[0]    = b1.mul_a;      assign o_ma[1]    = b4.mul_a;
    assign o_mx[0]    = b1.mul_x;      assign o_mx[1]    = b4.mul_x;

    // Transaction-level reference: an operation is granted, its response
    // appears latency+1 cycles later and stays until accepted; the next
    // grant can come the cycle after acceptance.
    int           m_busy [2] = '{0, 0};
    int           m_age  [2] = '{0, 0};
    int           m_id   [2] = '{0, 0};
    int           m_lg   [2] = '{N-1, N-1};
    vec_t         m_y    [2];
    vec_t         m_a    [2];
    vec_t         m_x    [2];
    logic [N-1:0] e_ready [2];
    logic         e_rv    [2];
    logic         e_busy  [2];

    task automatic model_advance();
        int p;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 0;
                m_lg[k]   = N - 1;
            end else if (m_busy[k] != 0) begin
                if (m_age[k] >= lat(k) + 1 && rsp_ready) m_busy[k] = 0;
                else m_age[k]++;
            end else begin
                p = rr_pick(req_valid, m_lg[k]);
                if (p >= 0) begin
                    m_busy[k] = 1;
                    m_age[k]  = 1;
                    m_id[k]   = p;
                    m_lg[k]   = p;
                    m_a[k]    = req_a[p];
                    m_x[k]    = req_x[p];
                    m_y[k]    = vmul(req_a[p], req_x[p]);
                end
            end
        end
    endtask

    task automatic model_expect();
        int p;
        for (int k = 0; k < 2; k++) begin
            p          = rr_pick(req_valid, m_lg[k]);
            e_ready[k] = (!rst && m_busy[k] == 0 && p >= 0) ? (4'b0001 << p) : 4'b0000;
            e_busy[k]  = (m_busy[k] != 0);
            e_rv[k]    = (m_busy[k] != 0) && (m_age[k] >= lat(k) + 1);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        model_advance();
    endtask

    task automatic settle();
        #3;
        model_expect();
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_ready[k] !== 4'b0000) begin bad++; $display("FAIL reset_no_grant dut%0d: got %b want 0000", k, o_ready[k]); end
        end
        next_cycle();
        settle();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_ready[k] !== 4'b0000 || o_busy[k] !== 1'b0 || o_rv[k] !== 1'b0 || o_id[k] !== 2'd0) begin
                bad++; $display("FAIL reset_ctrl dut%0d: got ready=%b busy=%b rv=%b id=%0d want 0", k, o_ready[k], o_busy[k], o_rv[k], o_id[k]);
            end
            total++;
            if (o_y[k] !== '0 || o_ma[k] !== '0 || o_mx[k] !== '0) begin
                bad++; $display("FAIL reset_data dut%0d: got y=%h a=%h x=%h want 0", k, o_y[k], o_ma[k], o_mx[k]);
            end
        end
        next_cycle();
        rst = 1'b0; req_valid = '0;
        settle();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_rv[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
                bad++; $display("FAIL idle_ready_ignored dut%0d: got rv=%b busy=%b want 0 0", k, o_rv[k], o_busy[k]);
            end
        end
    endtask

    task automatic test_single_latency();
        vec_t ey, ea;
        do_reset();
        next_cycle();
        rst = 1'b0; req_valid = 4'b0001; req_a = '0; req_x = '0;
        req_a[0][0] = 16'd1; req_x[0][0] = 16'd4; rsp_ready = 1'b1;
        settle();
        ey = '0; ey[0] = 16'd4;
        ea = '0; ea[0] = 16'd1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_ready[k] !== 4'b0001) begin bad++; $display("FAIL single_grant dut%0d: got %b want 0001", k, o_ready[k]); end
        end
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            req_valid = '0;
            settle();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_ready[k] !== 4'b0000) begin bad++; $display("FAIL single_ready_pulse dut%0d c%0d: got %b want 0000", k, c, o_ready[k]); end
            end
            total++;
            if (o_rv[0] !== (c == 2) || o_busy[0] !== (c <= 2)) begin
                bad++; $display("FAIL lat1_timing c%0d: got rv=%b busy=%b want %b %b", c, o_rv[0], o_busy[0], (c == 2), (c <= 2));
            end
            total++;
            if (o_rv[1] !== (c == 5) || o_busy[1] !== (c <= 5)) begin
                bad++; $display("FAIL lat4_timing c%0d: got rv=%b busy=%b want %b %b", c, o_rv[1], o_busy[1], (c == 5), (c <= 5));
            end
            if (c <= 2) begin
                total++;
                if (o_ma[0] !== ea || o_mx[0] !== ey) begin bad++; $display("FAIL single_operands c%0d: got a=%h x=%h", c, o_ma[0], o_mx[0]); end
            end
            if (c == 2 || c == 5) begin
                total++;
                if (o_id[c == 2 ? 0 : 1] !== 2'd0 || o_y[c == 2 ? 0 : 1] !== ey) begin
                    bad++; $display("FAIL single_result c%0d: got id=%0d y=%h want 0 %h", c, o_id[c == 2 ? 0 : 1], o_y[c == 2 ? 0 : 1], ey);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp1, exp4;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            next_cycle();
            rst = 1'b0; req_valid = '1; rsp_ready = 1'b1;
            for (int r = 0; r < N; r++) begin req_a[r] = rand_vec(); req_x[r] = rand_vec(); end
            settle();
            exp1 = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
            exp4 = (c % 6 == 0) ? (4'b0001 << ((c / 6) % 4)) : 4'b0000;
            total++;
            if (o_ready[0] !== exp1) begin bad++; $display("FAIL contention_lat1 c%0d: got %b want %b", c, o_ready[0], exp1); end
            total++;
            if (o_ready[1] !== exp4) begin bad++; $display("FAIL contention_lat4 c%0d: got %b want %b", c, o_ready[1], exp4); end
            if (c % 3 == 2) begin
                total++;
                if (o_rv[0] !== 1'b1 || o_id[0] !== 2'((c / 3) % 4)) begin
                    bad++; $display("FAIL contention_id c%0d: got rv=%b id=%0d want 1 %0d", c, o_rv[0], o_id[0], (c / 3) % 4);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        vec_t ea, ex, ey;
        do_reset();
        next_cycle();
        rst = 1'b0; req_valid = 4'b0001; rsp_ready = 1'b0;
        req_a[0] = rand_vec(); req_x[0] = rand_vec();
        ea = req_a[0]; ex = req_x[0]; ey = vmul(ea, ex);
        settle();
        total++;
        if (o_ready[0] !== 4'b0001) begin bad++; $display("FAIL bp_grant: got %b want 0001", o_ready[0]); end
        next_cycle();
        req_valid = 4'b0010; req_a[0] = rand_vec(); req_x[0] = rand_vec();
        settle();
        for (int c = 2; c <= 7; c++) begin
            next_cycle();
            rsp_ready = (c == 7);
            settle();
            total++;
            if (o_rv[0] !== 1'b1 || o_id[0] !== 2'd0 || o_y[0] !== ey || o_ready[0] !== 4'b0000) begin
                bad++; $display("FAIL bp_hold c%0d: got rv=%b id=%0d ready=%b y=%h want 1 0 0000 %h", c, o_rv[0], o_id[0], o_ready[0], o_y[0], ey);
            end
            total++;
            if (o_ma[0] !== ea || o_mx[0] !== ex) begin bad++; $display("FAIL bp_operands c%0d: got a=%h x=%h", c, o_ma[0], o_mx[0]); end
        end
        next_cycle();
        rsp_ready = 1'b0;
        settle();
        total++;
        if (o_rv[0] !== 1'b0 || o_ready[0] !== 4'b0010) begin
            bad++; $display("FAIL bp_next_grant: got rv=%b ready=%b want 0 0010", o_rv[0], o_ready[0]);
        end
    endtask

    task automatic test_truncation();
        do_reset();
        next_cycle();
        rst = 1'b0; req_valid = 4'b0010; rsp_ready = 1'b1;
        req_a[1] = rand_vec(); req_x[1] = rand_vec();
        req_a[1][1] = 16'hFFFF; req_x[1][1] = 16'h0002;
        settle();
        total++;
        if (o_ready[0] !== 4'b0010) begin bad++; $display("FAIL trunc_grant: got %b want 0010", o_ready[0]); end
        next_cycle(); req_valid = '0; settle();
        next_cycle(); settle();
        total++;
        if (o_rv[0] !== 1'b1 || o_id[0] !== 2'd1 || o_y[0][1] !== 16'hFFFE) begin
            bad++; $display("FAIL trunc_lane: got rv=%b id=%0d y1=%h want 1 1 fffe", o_rv[0], o_id[0], o_y[0][1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        next_cycle();
        rst = 1'b0; req_valid = 4'b0100; rsp_ready = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_ready[k] !== 4'b0100) begin bad++; $display("FAIL rmid_first dut%0d: got %b want 0100", k, o_ready[k]); end
        end
        next_cycle();
        rst = 1'b1; req_valid = 4'b0101;
        settle();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_ready[k] !== 4'b0000 || o_busy[k] !== 1'b1) begin
                bad++; $display("FAIL rmid_wait dut%0d: got ready=%b busy=%b want 0000 1", k, o_ready[k], o_busy[k]);
            end
        end
        next_cycle();
        rst = 1'b0;
        settle();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_ready[k] !== 4'b0001 || o_rv[k] !== 1'b0) begin
                bad++; $display("FAIL rmid_regrant dut%0d: got ready=%b rv=%b want 0001 0", k, o_ready[k], o_rv[k]);
            end
        end
        for (int c = 3; c <= 8; c++) begin
            next_cycle();
            req_valid = '0;
            settle();
            total++;
            if (o_rv[0] !== (c == 4) || o_rv[1] !== (c == 7)) begin
                bad++; $display("FAIL rmid_rsp c%0d: got rv1=%b rv4=%b want %b %b", c, o_rv[0], o_rv[1], (c == 4), (c == 7));
            end
            if (c == 4 || c == 7) begin
                total++;
                if (o_id[c == 4 ? 0 : 1] !== 2'd0) begin bad++; $display("FAIL rmid_id c%0d: got %0d want 0", c, o_id[c == 4 ? 0 : 1]); end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            rst       = ($urandom_range(0, 63) == 0);
            req_valid = 4'($urandom);
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            rsp_ready = 1'($urandom_range(0, 1));
            for (int r = 0; r < N; r++) begin req_a[r] = rand_vec(); req_x[r] = rand_vec(); end
            settle();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_ready[k] !== e_ready[k] || o_busy[k] !== e_busy[k] || o_rv[k] !== e_rv[k]) begin
                    bad++; $display("FAIL random_ctrl dut%0d c%0d: got ready=%b busy=%b rv=%b want %b %b %b",
                                    k, c, o_ready[k], o_busy[k], o_rv[k], e_ready[k], e_busy[k], e_rv[k]);
                end
                if (e_rv[k]) begin
                    total++;
                    if (o_id[k] !== 2'(m_id[k]) || o_y[k] !== m_y[k]) begin
                        bad++; $display("FAIL random_rsp dut%0d c%0d: got id=%0d y=%h want %0d %h", k, c, o_id[k], o_y[k], m_id[k], m_y[k]);
                    end
                end
                if (e_busy[k]) begin
                    total++;
                    if (o_ma[k] !== m_a[k] || o_mx[k] !== m_x[k]) begin
                        bad++; $display("FAIL random_operands dut%0d c%0d: got a=%h x=%h want %h %h", k, c, o_ma[k], o_mx[k], m_a[k], m_x[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_contention();
        test_back_pressure();
        test_truncation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
